// File: rtl/bus_scheduler_if.sv
// Requester and master-bus signal bundle for bus_scheduler.
// The scheduler takes the master modport; the requesters and bus units take the slave side.
interface bus_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]   i_req;
  logic [4*NUM_REQ-1:0] i_req_src;
  logic [4*NUM_REQ-1:0] i_req_dst;
  logic [4*NUM_REQ-1:0] i_req_rcmd;
  logic [4*NUM_REQ-1:0] i_req_wcmd;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_done;
  logic                 o_error;
  logic [3:0]           o_read_id;
  logic [3:0]           o_read_command;
  logic [3:0]           o_write_id;
  logic [3:0]           o_write_command;
  logic [DATA_W-1:0]    i_bus_data;
  logic                 i_bus_valid;
  logic [DATA_W-1:0]    o_bus_data;
  logic                 o_bus_valid;

  modport master (
    input  i_req, i_req_src, i_req_dst, i_req_rcmd, i_req_wcmd, i_bus_data, i_bus_valid,
    output o_grant, o_done, o_error, o_read_id, o_read_command,
           o_write_id, o_write_command, o_bus_data, o_bus_valid
  );

  modport slave (
    output i_req, i_req_src, i_req_dst, i_req_rcmd, i_req_wcmd, i_bus_data, i_bus_valid,
    input  o_grant, o_done, o_error, o_read_id, o_read_command,
           o_write_id, o_write_command, o_bus_data, o_bus_valid
  );
endinterface

// File: rtl/bus_scheduler.sv
// Round-robin scheduler moving one word per granted request from a source unit
// to a destination unit over a shared master bus (IDLE -> READ -> WRITE).
module bus_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  parameter int DATA_W  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  bus_scheduler_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d, win_q, win_d, pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, req_eff;
  logic               err_q, err_d, found, latch, capture;
  logic [3:0]         src_q, dst_q, rcmd_q, wcmd_q, sel_src, sel_dst;
  word_t              data_q;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
    found   = 1'b0;
    pick    = '0;
    // A requester answered by an illegal-ID pulse may still show its request this cycle.
    req_eff = bus.i_req & ~grant_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    sel_src = bus.i_req_src[4*int'(pick) +: 4];
    sel_dst = bus.i_req_dst[4*int'(pick) +: 4];

    case (state_q)
      IDLE: begin
        if (found) begin
          latch   = 1'b1;
          win_d   = pick;
          rr_d    = (int'(pick) == NUM_REQ - 1) ? '0 : pick + PTR_W'(1);
          grant_d = onehot(pick);
          if (sel_src == 4'h0 || sel_dst == 4'h0) begin
            done_d = onehot(pick);
            err_d  = 1'b1;
          end else begin
            state_d = READ;
            cnt_d   = '0;
          end
        end
      end
      READ: begin
        if (bus.i_bus_valid) begin
          capture = 1'b1;
          state_d = WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          done_d  = onehot(win_q);
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Transfer payload registers; every output use is gated by the FSM state.
  always_ff @(posedge i_clk) begin
    if (latch) begin
      src_q  <= sel_src;
      dst_q  <= sel_dst;
      rcmd_q <= bus.i_req_rcmd[4*int'(pick) +: 4];
      wcmd_q <= bus.i_req_wcmd[4*int'(pick) +: 4];
    end
    if (capture) data_q <= bus.i_bus_data;
  end

  assign bus.o_grant         = grant_q;
  assign bus.o_done          = done_q | ((state_q == WRITE) ? onehot(win_q) : '0);
  assign bus.o_error         = err_q;
  assign bus.o_read_id       = (state_q == READ)  ? src_q  : 4'h0;
  assign bus.o_read_command  = (state_q == READ)  ? rcmd_q : 4'h0;
  assign bus.o_write_id      = (state_q == WRITE) ? dst_q  : 4'h0;
  assign bus.o_write_command = (state_q == WRITE) ? wcmd_q : 4'h0;
  assign bus.o_bus_data      = (state_q == WRITE) ? data_q : '0;
  assign bus.o_bus_valid     = (state_q == WRITE);
endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_scheduler;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  bus_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [N-1:0]  e_grant = '0, e_done = '0;
  logic          e_err = 1'b0, e_bvalid = 1'b0;
  logic [3:0]    e_rid = '0, e_rcmd = '0, e_wid = '0, e_wcmd = '0;
  logic [DW-1:0] e_bdata = '0;

  task automatic clear_exp();
    e_grant = '0; e_done = '0; e_err = 1'b0; e_bvalid = 1'b0;
    e_rid = '0; e_rcmd = '0; e_wid = '0; e_wcmd = '0; e_bdata = '0;
  endtask

  initial begin : model
    int rr, w;
    logic [N-1:0] masked, reqs, nxt_grant, nxt_done;
    logic nxt_err, got, aborted;
    logic [3:0] s, d, rc, wc;
    logic [DW-1:0] data;
    rr = 0; masked = '0; nxt_grant = '0; nxt_done = '0; nxt_err = 1'b0;
    forever begin
      clear_exp();
      e_grant = nxt_grant; e_done = nxt_done; e_err = nxt_err;
      nxt_grant = '0; nxt_done = '0; nxt_err = 1'b0;
      @(posedge clk);
      if (!rst_n) begin rr = 0; masked = '0; continue; end
      reqs = bus.i_req & ~masked;
      masked = '0;
      if (reqs == '0) continue;
      w = -1;
      for (int i = 0; i < N; i++) if (w < 0 && reqs[(rr + i) % N]) w = (rr + i) % N;
      rr = (w + 1) % N;
      s = bus.i_req_src[4*w +: 4];  d = bus.i_req_dst[4*w +: 4];
      rc = bus.i_req_rcmd[4*w +: 4]; wc = bus.i_req_wcmd[4*w +: 4];
      if (s == 4'h0 || d == 4'h0) begin
        nxt_grant = N'(1) << w; nxt_done = N'(1) << w; nxt_err = 1'b1; masked = N'(1) << w;
        continue;
      end
      got = 1'b0; aborted = 1'b0; data = '0;
      for (int k = 0; k < TO; k++) begin
        clear_exp();
        e_rid = s; e_rcmd = rc;
        if (k == 0) e_grant = N'(1) << w;
        @(posedge clk);
        if (!rst_n) begin aborted = 1'b1; break; end
        if (bus.i_bus_valid) begin data = bus.i_bus_data; got = 1'b1; break; end
      end
      if (aborted) begin rr = 0; continue; end
      if (got) begin
        clear_exp();
        e_wid = d; e_wcmd = wc; e_bdata = data; e_bvalid = 1'b1; e_done = N'(1) << w;
        @(posedge clk);
        if (!rst_n) rr = 0;
      end else begin
        nxt_done = N'(1) << w; nxt_err = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int unsigned grant_log[$];
  int rd_cycles, bv_cnt, done_cnt, ids_nonzero;
  logic [N-1:0] last_done, gd_same;
  logic last_err;
  logic [3:0] last_wid, last_wcmd, last_rid;
  logic [DW-1:0] last_wdata;

  task automatic clear_log();
    grant_log.delete();
    rd_cycles = 0; bv_cnt = 0; done_cnt = 0; ids_nonzero = 0;
    last_done = '0; gd_same = '0; last_err = 1'b0;
    last_wid = '0; last_wcmd = '0; last_rid = '0; last_wdata = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_grant", bus.o_grant, 0);     chk("rst_done", bus.o_done, 0);
      chk("rst_error", bus.o_error, 0);     chk("rst_read_id", bus.o_read_id, 0);
      chk("rst_write_id", bus.o_write_id, 0); chk("rst_bus_data", bus.o_bus_data, 0);
      chk("rst_bus_valid", bus.o_bus_valid, 0);
    end else begin
      chk("grant", bus.o_grant, e_grant);       chk("done", bus.o_done, e_done);
      chk("error", bus.o_error, e_err);         chk("read_id", bus.o_read_id, e_rid);
      chk("read_cmd", bus.o_read_command, e_rcmd);
      chk("write_id", bus.o_write_id, e_wid);   chk("write_cmd", bus.o_write_command, e_wcmd);
      chk("bus_data", bus.o_bus_data, e_bdata); chk("bus_valid", bus.o_bus_valid, e_bvalid);
      for (int i = 0; i < N; i++) if (bus.o_grant[i]) grant_log.push_back(i);
      if (bus.o_read_id != 0) begin rd_cycles++; last_rid = bus.o_read_id; end
      if (bus.o_read_id != 0 || bus.o_write_id != 0) ids_nonzero++;
      if (bus.o_bus_valid) begin
        bv_cnt++; last_wdata = bus.o_bus_data; last_wid = bus.o_write_id; last_wcmd = bus.o_write_command;
      end
      if (bus.o_done != 0) begin done_cnt++; last_done = bus.o_done; last_err = bus.o_error; end
      if (bus.o_grant != 0 && bus.o_done != 0) gd_same = bus.o_grant & bus.o_done;
    end
  end

  // ---------------- stimulus ----------------
  int valid_at = -1;
  int rd_idx = -1;
  bit prev_read = 0;
  bit autodrop = 1;
  logic [DW-1:0] vdata = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (autodrop) bus.i_req = bus.i_req & ~bus.o_grant;
    if (bus.o_read_id != 0) begin
      rd_idx = prev_read ? rd_idx + 1 : 0;
      prev_read = 1;
    end else begin
      prev_read = 0; rd_idx = -1;
    end
    bus.i_bus_valid = prev_read && (rd_idx == valid_at);
    bus.i_bus_data  = vdata;
  endtask

  task automatic set_req(input int k, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] rc, input logic [3:0] wc);
    bus.i_req_src[4*k +: 4] = s;  bus.i_req_dst[4*k +: 4] = d;
    bus.i_req_rcmd[4*k +: 4] = rc; bus.i_req_wcmd[4*k +: 4] = wc;
    bus.i_req[k] = 1'b1;
  endtask

  initial begin
    int n;
    bus.i_req = '0; bus.i_req_src = '0; bus.i_req_dst = '0;
    bus.i_req_rcmd = '0; bus.i_req_wcmd = '0; bus.i_bus_data = '0; bus.i_bus_valid = 1'b0;
    clear_log();
    repeat (3) tick();
    chk("reset_read_id", bus.o_read_id, 0);
    chk("reset_done", bus.o_done, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Fairness: all four held continuously from reset
    clear_log(); autodrop = 0; valid_at = 0; vdata = 16'h0F0F;
    for (int k = 0; k < N; k++) set_req(k, 4'(k + 1), 4'(k + 5), 4'h1, 4'h2);
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin tick(); n++; end
    chk("fair_grant_count", grant_log.size(), 5);
    bus.i_req = '0; autodrop = 1;
    repeat (4) tick();
    if (grant_log.size() >= 5) begin
      chk("fair_g0", grant_log[0], 0); chk("fair_g1", grant_log[1], 1);
      chk("fair_g2", grant_log[2], 2); chk("fair_g3", grant_log[3], 3);
      chk("fair_g4", grant_log[4], 0);
    end

    // Single transfer
    clear_log(); valid_at = 0; vdata = 16'hA5A5;
    set_req(0, 4'h1, 4'h2, 4'h3, 4'h5);
    repeat (6) tick();
    chk("single_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_grant_idx", grant_log[0], 0);
    chk("single_write_id", last_wid, 4'h2);
    chk("single_write_cmd", last_wcmd, 4'h5);
    chk("single_bus_data", last_wdata, 16'hA5A5);
    chk("single_done", last_done, 4'b0001);
    chk("single_error", last_err, 0);
    chk("single_read_cycles", rd_cycles, 1);

    // Timeout
    clear_log(); valid_at = -1;
    set_req(1, 4'h3, 4'h4, 4'h6, 4'h7);
    repeat (22) tick();
    chk("to_read_cycles", rd_cycles, 15);
    chk("to_read_id", last_rid, 4'h3);
    chk("to_done", last_done, 4'b0010);
    chk("to_error", last_err, 1);
    chk("to_bus_valid", bv_cnt, 0);

    // Illegal source ID
    clear_log();
    set_req(2, 4'h0, 4'h5, 4'h1, 4'h1);
    repeat (4) tick();
    chk("ill_grant_done_same", gd_same, 4'b0100);
    chk("ill_error", last_err, 1);
    chk("ill_ids_idle", ids_nonzero, 0);
    chk("ill_done_count", done_cnt, 1);

    // Valid on the last READ cycle beats the timeout
    clear_log(); valid_at = 14; vdata = 16'h1234;
    set_req(3, 4'h6, 4'h7, 4'h8, 4'h9);
    repeat (20) tick();
    chk("race_read_cycles", rd_cycles, 15);
    chk("race_bus_valid", bv_cnt, 1);
    chk("race_bus_data", last_wdata, 16'h1234);
    chk("race_done", last_done, 4'b1000);
    chk("race_error", last_err, 0);

    // Src == dst is legal
    clear_log(); valid_at = 2; vdata = 16'hBEEF;
    set_req(1, 4'h9, 4'h9, 4'h2, 4'h4);
    repeat (8) tick();
    chk("same_write_id", last_wid, 4'h9);
    chk("same_bus_data", last_wdata, 16'hBEEF);
    chk("same_error", last_err, 0);

    // Reset in the middle of READ
    clear_log(); valid_at = -1;
    set_req(0, 4'h1, 4'h2, 4'h3, 4'h4);
    n = 0;
    while (rd_cycles < 4 && n < 30) begin tick(); n++; end
    chk("pre_rst_read_id", bus.o_read_id, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_read_id", bus.o_read_id, 0);
    chk("async_rst_read_cmd", bus.o_read_command, 0);
    repeat (3) tick();
    chk("rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    clear_log(); valid_at = 0; vdata = 16'h5555;
    set_req(1, 4'h2, 4'h3, 4'h1, 4'h1);
    set_req(0, 4'h4, 4'h5, 4'h1, 4'h1);
    repeat (10) tick();
    chk("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("post_rst_first", grant_log[0], 0);
      chk("post_rst_second", grant_log[1], 1);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
